fastica_iter_ctrl: RTL and testbench

Iteration sequencer for the one-unit FastICA datapath. It drives the expectation unit, the 4x4 weight subtractor and the normaliser in a fixed order, then streams the 16 weight elements through an internal convergence checker. It repeats until the weights converge or an iteration cap is reached, and owns the enables of those three units.

---
 rtl/fastica_iter_ctrl_if.sv | 29 ++
 rtl/fastica_iter_ctrl.sv | 135 +++++++++++++
 tb/tb_fastica_iter_ctrl.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/fastica_iter_ctrl_if.sv
// rtl/fastica_iter_ctrl_if.sv - handshake and check-stream bundle for the FastICA iteration sequencer
interface fastica_iter_ctrl_if #(
  parameter int DW = 26
);
  logic                 start;
  logic                 exp_done;
  logic                 norm_done;
  logic signed [DW-1:0] chk_new;
  logic signed [DW-1:0] chk_old;
  logic                 en_exp;
  logic                 en_sub;
  logic                 en_norm;
  logic                 en_wold;
  logic [3:0]           chk_idx;
  logic                 busy;
  logic                 done;
  logic                 converged;
  logic [6:0]           iter_cnt;

  modport master (
    input  start, exp_done, norm_done, chk_new, chk_old,
    output en_exp, en_sub, en_norm, en_wold, chk_idx, busy, done, converged, iter_cnt
  );

  modport slave (
    output start, exp_done, norm_done, chk_new, chk_old,
    input  en_exp, en_sub, en_norm, en_wold, chk_idx, busy, done, converged, iter_cnt
  );
endinterface

// File: rtl/fastica_iter_ctrl.sv
// rtl/fastica_iter_ctrl.sv - FastICA iteration sequencer with built-in weight convergence checker
module fastica_iter_ctrl #(
  parameter int DW       = 26,
  parameter int MAX_ITER = 64,
  parameter int TOL      = 64
) (
  input  logic                 clk_ctl,
  input  logic                 rstn_ctl,
  fastica_iter_ctrl_if.master  bus
);

  typedef enum logic [3:0] {
    S_IDLE, S_EXP, S_EXPW, S_SUB, S_SUBW, S_NORM, S_NORMW, S_CHK, S_DEC, S_FIN
  } state_t;

  localparam logic [DW:0] TOL_V = (DW+1)'(TOL);
  localparam logic [DW:0] ONE_V = (DW+1)'(1);
  localparam logic [6:0]  MAX_V = 7'(MAX_ITER);

  state_t      state, state_nxt;
  logic [3:0]  idx;
  logic [6:0]  iter;
  logic        conv;
  logic        pass_d, pass_s;
  logic        en_exp, en_sub, en_norm, en_wold, busy, done;

  logic [DW:0] diff, sum, diff_abs, sum_abs;
  logic        within_d, within_s;
  logic        dec_conv, dec_cap;

  // One extra bit keeps new +/- old exact; the magnitude of -2^DW is then 2^DW unsigned.
  assign diff     = {bus.chk_new[DW-1], bus.chk_new} - {bus.chk_old[DW-1], bus.chk_old};
  assign sum      = {bus.chk_new[DW-1], bus.chk_new} + {bus.chk_old[DW-1], bus.chk_old};
  assign diff_abs = diff[DW] ? (~diff + ONE_V) : diff;
  assign sum_abs  = sum[DW]  ? (~sum  + ONE_V) : sum;
  assign within_d = (diff_abs <= TOL_V);
  assign within_s = (sum_abs  <= TOL_V);

  // Iteration 0 has no valid old weights, so it can never declare convergence.
  assign dec_conv = (iter != 7'd0) && (pass_d || pass_s);
  assign dec_cap  = ((iter + 7'd1) == MAX_V);

  always_comb begin
    state_nxt = state;
    en_exp    = 1'b0;
    en_sub    = 1'b0;
    en_norm   = 1'b0;
    en_wold   = 1'b0;
    done      = 1'b0;
    busy      = (state != S_IDLE);
    case (state)
      S_IDLE:  if (bus.start) state_nxt = S_EXP;
      S_EXP: begin
        en_exp    = 1'b1;
        state_nxt = S_EXPW;
      end
      S_EXPW:  if (bus.exp_done) state_nxt = S_SUB;
      S_SUB: begin
        en_sub    = 1'b1;
        state_nxt = S_SUBW;
      end
      S_SUBW:  state_nxt = S_NORM;
      S_NORM: begin
        en_norm   = 1'b1;
        state_nxt = S_NORMW;
      end
      S_NORMW: if (bus.norm_done) state_nxt = (iter == 7'd0) ? S_DEC : S_CHK;
      S_CHK:   if (idx == 4'd15) state_nxt = S_DEC;
      S_DEC: begin
        if (dec_conv || dec_cap) begin
          state_nxt = S_FIN;
        end else begin
          en_wold   = 1'b1;
          state_nxt = S_EXP;
        end
      end
      S_FIN: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_ctl) begin
    if (!rstn_ctl) begin
      state  <= S_IDLE;
      idx    <= 4'd0;
      iter   <= 7'd0;
      conv   <= 1'b0;
      pass_d <= 1'b1;
      pass_s <= 1'b1;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            iter   <= 7'd0;
            conv   <= 1'b0;
            pass_d <= 1'b1;
            pass_s <= 1'b1;
          end
        end
        S_NORMW: begin
          if (bus.norm_done) begin
            pass_d <= 1'b1;
            pass_s <= 1'b1;
          end
        end
        S_CHK: begin
          // 4-bit index wraps back to 0 as CHK exits, so it reads 0 elsewhere.
          idx <= idx + 4'd1;
          if (!within_d) pass_d <= 1'b0;
          if (!within_s) pass_s <= 1'b0;
        end
        S_DEC: begin
          iter <= iter + 7'd1;
          if (dec_conv || dec_cap) conv <= dec_conv;
        end
        default: ;
      endcase
    end
  end

  assign bus.en_exp    = en_exp;
  assign bus.en_sub    = en_sub;
  assign bus.en_norm   = en_norm;
  assign bus.en_wold   = en_wold;
  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.chk_idx   = idx;
  assign bus.converged = conv;
  assign bus.iter_cnt  = iter;

endmodule

// File: tb/tb_fastica_iter_ctrl.sv
// tb/tb_fastica_iter_ctrl.sv - directed self-checking bench for fastica_iter_ctrl
module tb_fastica_iter_ctrl;
  localparam int DW = 26;
  localparam logic signed [DW-1:0] MAXP = {1'b0, {(DW-1){1'b1}}};
  localparam logic signed [DW-1:0] MINN = {1'b1, {(DW-1){1'b0}}};

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  fastica_iter_ctrl_if #(.DW(DW)) bus ();

  fastica_iter_ctrl #(.DW(DW), .MAX_ITER(4), .TOL(64)) dut (
    .clk_ctl  (clk),
    .rstn_ctl (rstn),
    .bus      (bus)
  );

  logic signed [DW-1:0] new_tab [16];
  logic signed [DW-1:0] old_tab [16];
  logic start     = 1'b0;
  logic spur_exp  = 1'b0;
  logic resp_exp  = 1'b0;
  logic resp_norm = 1'b0;
  logic cnt_clr   = 1'b0;
  int   n_sub, n_wold, n_done;
  int   checks = 0;
  int   errors = 0;

  assign bus.start     = start;
  assign bus.exp_done  = resp_exp | spur_exp;
  assign bus.norm_done = resp_norm;
  assign bus.chk_new   = new_tab[bus.chk_idx];
  assign bus.chk_old   = old_tab[bus.chk_idx];

  logic [17:0] outs;
  assign outs = {bus.en_exp, bus.en_sub, bus.en_norm, bus.en_wold, bus.chk_idx,
                 bus.busy, bus.done, bus.converged, bus.iter_cnt};

  // Zero-latency units: each done pulse arrives the cycle after its start pulse.
  always @(posedge clk) begin
    resp_exp  <= bus.en_exp;
    resp_norm <= bus.en_norm;
    if (cnt_clr) begin
      n_sub  <= 0;
      n_wold <= 0;
      n_done <= 0;
    end else begin
      n_sub  <= n_sub  + (bus.en_sub  ? 1 : 0);
      n_wold <= n_wold + (bus.en_wold ? 1 : 0);
      n_done <= n_done + (bus.done    ? 1 : 0);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic fill(input logic signed [DW-1:0] a, input logic signed [DW-1:0] b);
    for (int i = 0; i < 16; i++) begin
      new_tab[i] = a;
      old_tab[i] = b;
    end
  endtask

  task automatic clear_counts();
    cnt_clr = 1'b1;
    step(1);
    cnt_clr = 1'b0;
  endtask

  task automatic run(input string tag, input bit hold, input logic exp_conv,
                     input int exp_iter, input int exp_wold, input int exp_cyc);
    int cyc;
    bit seen;
    clear_counts();
    start    = 1'b1;
    spur_exp = hold;
    step(1);
    if (!hold) start = 1'b0;
    cyc  = 1;
    seen = 1'b0;
    while (cyc < 400 && !seen) begin
      if (bus.done) seen = 1'b1;
      else begin
        step(1);
        cyc++;
      end
    end
    start    = 1'b0;
    spur_exp = 1'b0;
    check({tag, " done_seen"}, 32'(seen), 32'd1);
    check({tag, " cycles"}, 32'(cyc), 32'(exp_cyc));
    check({tag, " converged"}, 32'(bus.converged), 32'(exp_conv));
    check({tag, " iter_cnt"}, 32'(bus.iter_cnt), 32'(exp_iter));
    step(1);
    check({tag, " busy_after"}, 32'(bus.busy), 32'd0);
    check({tag, " conv_hold"}, 32'(bus.converged), 32'(exp_conv));
    check({tag, " n_sub"}, 32'(n_sub), 32'(exp_iter));
    check({tag, " n_wold"}, 32'(n_wold), 32'(exp_wold));
    check({tag, " n_done"}, 32'(n_done), 32'd1);
  endtask

  initial begin
    int  c;
    bit  hit;
    fill(26'sd0, 26'sd0);
    step(3);
    check("reset outs", 32'(outs), 32'd0);
    rstn = 1'b1;
    step(1);
    check("idle outs", 32'(outs), 32'd0);

    // Cycle-accurate walk through a two-iteration run with matching weights.
    fill(26'sd100, 26'sd100);
    clear_counts();
    start = 1'b1;
    step(1);
    start = 1'b0;
    check("c1 en_exp", 32'(bus.en_exp), 32'd1);
    check("c1 busy", 32'(bus.busy), 32'd1);
    step(2);
    check("c3 en_sub", 32'(bus.en_sub), 32'd1);
    step(2);
    check("c5 en_norm", 32'(bus.en_norm), 32'd1);
    step(2);
    check("c7 en_wold", 32'(bus.en_wold), 32'd1);
    step(1);
    check("c8 en_exp", 32'(bus.en_exp), 32'd1);
    check("c8 iter_cnt", 32'(bus.iter_cnt), 32'd1);
    step(13);
    check("c21 chk_idx", 32'(bus.chk_idx), 32'd7);
    step(8);
    check("c29 chk_idx", 32'(bus.chk_idx), 32'd15);
    step(1);
    check("c30 chk_idx", 32'(bus.chk_idx), 32'd0);
    check("c30 done", 32'(bus.done), 32'd0);
    step(1);
    check("c31 done", 32'(bus.done), 32'd1);
    check("c31 converged", 32'(bus.converged), 32'd1);
    check("c31 iter_cnt", 32'(bus.iter_cnt), 32'd2);
    step(1);
    check("c32 busy", 32'(bus.busy), 32'd0);
    check("c32 n_sub", 32'(n_sub), 32'd2);
    check("c32 n_wold", 32'(n_wold), 32'd1);
    check("c32 n_done", 32'(n_done), 32'd1);

    for (int i = 0; i < 16; i++) begin
      new_tab[i] = i[0] ? 26'sd5000 : -26'sd5000;
      old_tab[i] = -new_tab[i];
    end
    run("signflip", 1'b0, 1'b1, 2, 1, 31);

    fill(26'sd7, 26'sd7);
    new_tab[15] = 26'sd72;
    run("diff65", 1'b0, 1'b0, 4, 3, 77);
    new_tab[15] = 26'sd71;
    run("diff64", 1'b0, 1'b1, 2, 1, 31);

    // Idx0 only passes pass_d if the difference wraps; idx1 only passes pass_s if the sum wraps.
    fill(26'sd0, 26'sd0);
    new_tab[0] = MAXP;
    old_tab[0] = MINN;
    new_tab[1] = MINN;
    old_tab[1] = MINN;
    run("extreme", 1'b0, 1'b0, 4, 3, 77);
    fill(MINN, MINN);
    run("minmin", 1'b0, 1'b1, 2, 1, 31);

    fill(26'sd100, 26'sd100);
    run("noise", 1'b1, 1'b1, 2, 1, 31);

    clear_counts();
    start = 1'b1;
    step(1);
    start = 1'b0;
    hit = 1'b0;
    c = 0;
    while (c < 100 && !hit) begin
      if (bus.chk_idx == 4'd7) hit = 1'b1;
      else begin
        step(1);
        c++;
      end
    end
    check("abort reached idx7", 32'(hit), 32'd1);
    rstn = 1'b0;
    step(1);
    check("abort outs", 32'(outs), 32'd0);
    rstn = 1'b1;
    step(2);
    check("abort no done", 32'(n_done), 32'd0);
    run("post_abort", 1'b0, 1'b1, 2, 1, 31);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
